// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command-frame controller.
// State encoding and opcode constants.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DRAIN,
    ERR
  } state_e;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_WR  = 8'h02;
  localparam logic [7:0] OP_RD  = 8'h03;

endpackage

// File: rtl/spi_ss_sync.sv
// Two-flop chip-select synchroniser with edge pulses.
// All flops reset to the inactive (high) level.
module spi_ss_sync (
  input  logic clk,
  input  logic rst,
  input  logic ss_i,
  output logic ss_o,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= ss_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign ss_o   = sync_q;
  assign fall_o = prev_q & ~sync_q;
  assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Decodes SPI frames (opcode, address, data words)
// into register-bank read/write strobes.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int DATA_BYTES = 2,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_ss,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  output logic [7:0]            reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wr_data,
  output logic                  frame_err,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  localparam int W = 8 * DATA_BYTES;
  localparam logic [2:0] LAST = 3'(DATA_BYTES - 1);

  logic ss_s;
  logic ss_fall;
  logic ss_rise;

  state_e st_q, st_d;
  logic [7:0]   addr_q, addr_d;
  logic [W-1:0] word_q, word_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         words_q, words_d;
  logic         rd_q, rd_d;
  logic         arm_q;
  logic [1:0]   settle_q;

  logic         wr_q, wr_d;
  logic         rs_q, rs_d;
  logic         err_q, err_d;
  logic [7:0]   oaddr_q, oaddr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [15:0]  fcnt_q, fcnt_d;

  logic [W+7:0] sh;
  logic         good;

  spi_ss_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .ss_i   (spi_ss),
    .ss_o   (ss_s),
    .fall_o (ss_fall),
    .rise_o (ss_rise)
  );

  always_comb begin
    st_d    = st_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    rd_d    = rd_q;
    wr_d    = 1'b0;
    rs_d    = 1'b0;
    err_d   = 1'b0;
    oaddr_d = oaddr_q;
    wdata_d = wdata_q;
    fcnt_d  = fcnt_q;
    sh      = {word_q, byte_data};
    good    = 1'b0;
    if (st_q == IDLE) begin
      if (ss_fall && arm_q) st_d = CMD;
    end else begin
      if (byte_en) begin
        unique case (st_q)
          CMD: begin
            unique case (1'b1)
              (byte_data == OP_WR): begin
                st_d = ADDR;
                rd_d = 1'b0;
              end
              (byte_data == OP_RD): begin
                st_d = ADDR;
                rd_d = 1'b1;
              end
              (byte_data == OP_NOP): st_d = DRAIN;
              default: begin
                st_d  = ERR;
                err_d = 1'b1;
              end
            endcase
          end
          ADDR: begin
            addr_d = byte_data;
            if (rd_q) begin
              rs_d    = 1'b1;
              oaddr_d = byte_data;
              st_d    = DRAIN;
            end else begin
              cnt_d   = 3'd0;
              words_d = 1'b0;
              st_d    = DATA;
            end
          end
          DATA: begin
            word_d = sh[W-1:0];
            if (cnt_q == LAST) begin
              wr_d    = 1'b1;
              oaddr_d = addr_q;
              wdata_d = sh[W-1:0];
              cnt_d   = 3'd0;
              words_d = 1'b1;
              if (AUTO_INC) addr_d = addr_q + 8'd1;
              else st_d = DRAIN;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
      // Termination sees the state after any same-cycle byte.
      if (ss_rise) begin
        good = (st_d == CMD) || (st_d == DRAIN) ||
               (st_d == DATA && cnt_d == 3'd0 && words_d);
        if (good) fcnt_d = fcnt_q + 16'd1;
        else if (st_d != ERR) err_d = 1'b1;
        st_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      addr_q   <= 8'd0;
      word_q   <= '0;
      cnt_q    <= 3'd0;
      words_q  <= 1'b0;
      rd_q     <= 1'b0;
      arm_q    <= 1'b0;
      settle_q <= 2'd0;
      wr_q     <= 1'b0;
      rs_q     <= 1'b0;
      err_q    <= 1'b0;
      oaddr_q  <= 8'd0;
      wdata_q  <= '0;
      fcnt_q   <= 16'd0;
    end else begin
      st_q    <= st_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rs_q    <= rs_d;
      err_q   <= err_d;
      oaddr_q <= oaddr_d;
      wdata_q <= wdata_d;
      fcnt_q  <= fcnt_d;
      // A frame open across reset is ignored until ss is seen high.
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && ss_s) arm_q <= 1'b1;
    end
  end

  assign reg_wr_en   = wr_q;
  assign reg_rd_en   = rs_q;
  assign reg_addr    = oaddr_q;
  assign reg_wr_data = wdata_q;
  assign frame_err   = err_q;
  assign frame_cnt   = fcnt_q;
  assign busy        = ~ss_s & (st_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl: frame-level reference
// model feeds an expectation queue, a monitor checks strobes.
module tb_spi_cmd_ctrl;

  localparam int DB = 2;
  localparam bit AI = 1'b1;

  typedef struct {
    int            kind;
    logic [7:0]    addr;
    logic [8*DB-1:0] data;
    int            trig;
    int            cyc;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            spi_ss;
  logic            byte_en;
  logic [7:0]      byte_data;
  logic            reg_wr_en;
  logic            reg_rd_en;
  logic [7:0]      reg_addr;
  logic [8*DB-1:0] reg_wr_data;
  logic            frame_err;
  logic            busy;
  logic [15:0]     frame_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   exp_fcnt = 0;
  ev_t  sb[$];
  ev_t  me;
  int   mkind;
  bit   mok;
  logic [7:0] fq[$];

  spi_cmd_ctrl #(.DATA_BYTES(DB), .AUTO_INC(AI)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_ss      (spi_ss),
    .byte_en     (byte_en),
    .byte_data   (byte_data),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_en   (reg_rd_en),
    .reg_addr    (reg_addr),
    .reg_wr_data (reg_wr_data),
    .frame_err   (frame_err),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: which strobes a whole frame produces.
  task automatic model(input logic [7:0] fr[$], output ev_t evs[$],
                       output bit good);
    int n, d, nw;
    ev_t e;
    logic [8*DB-1:0] w, t;
    evs.delete();
    good = 1'b0;
    n = fr.size();
    e.addr = 8'h00;
    e.data = '0;
    e.cyc = -1;
    if (n == 0) good = 1'b1;
    else if (fr[0] == 8'h00) good = 1'b1;
    else if (fr[0] == 8'h03) begin
      if (n >= 2) begin
        e.kind = 1; e.addr = fr[1]; e.trig = 1;
        evs.push_back(e);
        good = 1'b1;
      end else begin
        e.kind = 2; e.trig = -1;
        evs.push_back(e);
      end
    end else if (fr[0] == 8'h02) begin
      d = (n >= 2) ? n - 2 : 0;
      nw = d / DB;
      if (!AI && nw > 1) nw = 1;
      for (int i = 0; i < nw; i++) begin
        w = '0;
        for (int k = 0; k < DB; k++) begin
          t = '0;
          t[7:0] = fr[2 + i * DB + k];
          w = (w << 8) | t;
        end
        e.kind = 0;
        e.addr = 8'(int'(fr[1]) + i);
        e.data = w;
        e.trig = 2 + (i + 1) * DB - 1;
        evs.push_back(e);
      end
      good = (n >= 2) && (nw > 0) && (AI ? (d % DB == 0) : 1'b1);
      if (!good) begin
        e.kind = 2; e.trig = -1;
        evs.push_back(e);
      end
    end else begin
      e.kind = 2; e.trig = 0;
      evs.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int c);
    byte_en = 1'b1;
    byte_data = b;
    @(posedge clk);
    #1;
    byte_en = 1'b0;
    c = cyc;
  endtask

  task automatic send_frame(input logic [7:0] fr[$]);
    ev_t evs[$];
    ev_t e;
    bit good;
    int c;
    model(fr, evs, good);
    spi_ss = 1'b0;
    tick(4);
    chk("busy_open", 32'(busy), 32'd1);
    for (int i = 0; i < fr.size(); i++) begin
      tick($urandom_range(0, 2));
      send_byte(fr[i], c);
      foreach (evs[k]) begin
        if (evs[k].trig == i) begin
          e = evs[k];
          e.cyc = c;
          sb.push_back(e);
        end
      end
    end
    tick(2);
    spi_ss = 1'b1;
    foreach (evs[k]) if (evs[k].trig < 0) sb.push_back(evs[k]);
    if (good) exp_fcnt = (exp_fcnt + 1) & 16'hFFFF;
    tick(6);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    chk("busy_closed", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && (reg_wr_en || reg_rd_en || frame_err)) begin
      n_chk++;
      mkind = reg_wr_en ? 0 : (reg_rd_en ? 1 : 2);
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d addr %0h data %0h expected none",
                 mkind, reg_addr, reg_wr_data);
      end else begin
        me = sb.pop_front();
        mok = (mkind == me.kind) && !(reg_wr_en && reg_rd_en) &&
              (me.cyc < 0 || me.cyc == cyc) &&
              (mkind == 2 || reg_addr == me.addr) &&
              (mkind != 0 || reg_wr_data == me.data);
        if (!mok) begin
          n_fail++;
          $display("FAIL event: got kind %0d addr %0h data %0h cyc %0d expected kind %0d addr %0h data %0h cyc %0d",
                   mkind, reg_addr, reg_wr_data, cyc,
                   me.kind, me.addr, me.data, me.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int len;
    int sel;
    rst = 1'b1;
    spi_ss = 1'b1;
    byte_en = 1'b0;
    byte_data = 8'h00;
    tick(3);
    chk("rst_strobes", 32'({reg_wr_en, reg_rd_en, frame_err, busy}), 32'd0);
    chk("rst_addr_data", 32'({reg_addr, reg_wr_data}), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    tick(5);

    fq = '{8'h02, 8'h10, 8'h12, 8'h34};
    send_frame(fq);
    fq = '{8'h02, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame(fq);
    fq = '{8'h03, 8'h20, 8'h55, 8'h66};
    send_frame(fq);
    fq = '{8'h55, 8'h10, 8'h12, 8'h34};
    send_frame(fq);
    fq = '{8'h02, 8'h01, 8'hAB, 8'hCD};
    send_frame(fq);
    fq = '{8'h02, 8'h10, 8'h12};
    send_frame(fq);
    fq.delete();
    send_frame(fq);
    fq = '{8'h02, 8'h40};
    send_frame(fq);
    fq = '{8'h00, 8'h02, 8'h10};
    send_frame(fq);

    spi_ss = 1'b0;
    tick(4);
    send_byte(8'h02, c);
    send_byte(8'h10, c);
    rst = 1'b1;
    tick(2);
    chk("midrst_out", 32'({reg_wr_en, reg_rd_en, frame_err, busy}), 32'd0);
    chk("midrst_fcnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    exp_fcnt = 0;
    tick(3);
    send_byte(8'h12, c);
    send_byte(8'h34, c);
    tick(3);
    chk("midrst_busy", 32'(busy), 32'd0);
    spi_ss = 1'b1;
    tick(6);
    chk("midrst_fcnt_end", 32'(frame_cnt), 32'd0);
    fq = '{8'h02, 8'h10, 8'h12, 8'h34};
    send_frame(fq);

    for (int f = 0; f < 30; f++) begin
      fq.delete();
      len = $urandom_range(0, 8);
      sel = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        if (i == 0)
          fq.push_back(sel == 0 ? 8'h02 : sel == 1 ? 8'h03 :
                       sel == 2 ? 8'h00 : 8'($urandom));
        else
          fq.push_back(8'($urandom));
      end
      send_frame(fq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
